// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,
    FS_WAIT  = 2'd1,
    FS_VALID = 2'd2
  } fs_state_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'hbfc00000;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [3:0]  SRAM_WEN_TIE   = 4'h0;
  localparam logic [31:0] SRAM_WDATA_TIE = 32'h0;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction SRAM port, ID handshake and branch redirect.
// FETCH_ADEL_EN adds the fs_adel address-error flag toward ID.
interface if_fetch_stage_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_valid;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
`ifdef FETCH_ADEL_EN
  logic        fs_adel;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
           fs_to_ds_valid, fs_pc, fs_inst, fs_adel,
    input  inst_sram_rdata, ds_allowin, br_valid, br_target
  );
  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
           fs_to_ds_valid, fs_pc, fs_inst, fs_adel,
    output inst_sram_rdata, ds_allowin, br_valid, br_target
  );
`else
  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
           fs_to_ds_valid, fs_pc, fs_inst,
    input  inst_sram_rdata, ds_allowin, br_valid, br_target
  );
  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
           fs_to_ds_valid, fs_pc, fs_inst,
    output inst_sram_rdata, ds_allowin, br_valid, br_target
  );
`endif
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with configurable SRAM read latency and branch kill.
// FETCH_ADEL_EN: misaligned PCs skip the SRAM and raise fs_adel instead.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          SRAM_LAT = 1,
  parameter int          CNT_W    = 3
) (
  input logic             clk,
  input logic             resetn,
  if_fetch_stage_if.master fs
);

  fs_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic [31:0]      inst_q, inst_d;
  logic             adel_q, adel_d;

  logic [31:0] req_pc;
  logic        hs, want_req, adel_hit, lat_done;

  // A request goes out from S_REQ, or on the accepting cycle of S_VALID.
  assign hs       = (state_q == FS_VALID) && !fs.br_valid && fs.ds_allowin;
  assign want_req = (state_q == FS_REQ) || hs;
  assign req_pc   = (state_q == FS_REQ) ? (fs.br_valid ? fs.br_target : pc_q)
                                        : pc_q + PC_STEP;
  assign lat_done = cnt_q == CNT_W'(SRAM_LAT);
`ifdef FETCH_ADEL_EN
  assign adel_hit = pc_misaligned(req_pc);
  assign fs.fs_adel = adel_q;
`else
  assign adel_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      inst_q  <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      adel_q  <= adel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    adel_d  = adel_q;
    if (want_req) begin
      pc_d = req_pc;
      if (adel_hit) begin
        state_d = FS_VALID;
        inst_d  = '0;
        adel_d  = 1'b1;
      end else begin
        state_d = FS_WAIT;
        cnt_d   = CNT_W'(1);
        adel_d  = 1'b0;
      end
    end else begin
      case (state_q)
        FS_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fs.br_valid) pc_d = fs.br_target;
          if (lat_done) begin
            inst_d = fs.inst_sram_rdata;
            // A redirect landing on the return cycle kills that word too.
            if (kill_q || fs.br_valid) begin
              state_d = FS_REQ;
              kill_d  = 1'b0;
            end else begin
              state_d = FS_VALID;
            end
          end else if (fs.br_valid) begin
            kill_d = 1'b1;
          end
        end
        FS_VALID: begin
          if (fs.br_valid) begin
            pc_d    = fs.br_target;
            state_d = FS_REQ;
          end
        end
        default: state_d = FS_REQ;
      endcase
    end
  end

  always_comb begin
    fs.inst_sram_en    = resetn && want_req && !adel_hit;
    fs.inst_sram_addr  = req_pc;
    fs.inst_sram_wen   = SRAM_WEN_TIE;
    fs.inst_sram_wdata = SRAM_WDATA_TIE;
    fs.fs_to_ds_valid  = resetn && (state_q == FS_VALID) && !fs.br_valid;
    fs.fs_pc           = pc_q;
    fs.fs_inst         = inst_q;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: one instance at SRAM_LAT=1, one at SRAM_LAT=3.
module tb_if_fetch_stage;
  localparam logic [31:0] MASK = 32'hffff0000;
  localparam logic [31:0] DEAD = 32'hdeadbeef;

  logic clk = 1'b0;
  logic rstn1, rstn3;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if f1 ();
  if_fetch_stage_if f3 ();

  if_fetch_stage #(.RESET_PC(32'hbfc00000), .SRAM_LAT(1), .CNT_W(3))
    dut1 (.clk(clk), .resetn(rstn1), .fs(f1));
  if_fetch_stage #(.RESET_PC(32'hbfc00000), .SRAM_LAT(3), .CNT_W(3))
    dut3 (.clk(clk), .resetn(rstn3), .fs(f3));

  // SRAM models: word = addr ^ MASK, valid exactly SRAM_LAT cycles after the request.
  logic        e1 = 1'b0;
  logic [31:0] a1 = '0;
  logic        e3 [0:2] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] a3 [0:2] = '{32'h0, 32'h0, 32'h0};
  always @(posedge clk) begin
    e1 <= f1.inst_sram_en; a1 <= f1.inst_sram_addr;
    e3[2] <= e3[1]; e3[1] <= e3[0]; e3[0] <= f3.inst_sram_en;
    a3[2] <= a3[1]; a3[1] <= a3[0]; a3[0] <= f3.inst_sram_addr;
  end
  assign f1.inst_sram_rdata = e1 ? (a1 ^ MASK) : DEAD;
  assign f3.inst_sram_rdata = e3[2] ? (a3[2] ^ MASK) : DEAD;

  task tick; @(posedge clk); #2; endtask

  task idle;
    f1.ds_allowin = 1'b1; f1.br_valid = 1'b0; f1.br_target = 32'h0;
    f3.ds_allowin = 1'b1; f3.br_valid = 1'b0; f3.br_target = 32'h0;
  endtask

  // Hold both in reset, then release; returns #1 into cycle C0 after release.
  task rst_hold;
    rstn1 = 1'b0; rstn3 = 1'b0; idle();
    tick(); tick();
  endtask
  task release_rst; rstn1 = 1'b1; rstn3 = 1'b1; #1; endtask

  task test_reset;
    rst_hold(); #1;
    checks++; if (f1.inst_sram_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", f1.inst_sram_en); end
    checks++; if (f1.fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", f1.fs_to_ds_valid); end
    checks++; if (f1.fs_pc !== 32'hbfc00000) begin errors++; $display("FAIL rst_pc got=%h exp=bfc00000", f1.fs_pc); end
    checks++; if (f1.fs_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=0", f1.fs_inst); end
    checks++; if (f3.inst_sram_en !== 1'b0) begin errors++; $display("FAIL rst_en3 got=%b exp=0", f3.inst_sram_en); end
    checks++; if (f1.inst_sram_wen !== 4'h0 || f1.inst_sram_wdata !== 32'h0) begin errors++; $display("FAIL rst_tie got=%h/%h exp=0/0", f1.inst_sram_wen, f1.inst_sram_wdata); end
`ifdef FETCH_ADEL_EN
    checks++; if (f1.fs_adel !== 1'b0) begin errors++; $display("FAIL rst_adel got=%b exp=0", f1.fs_adel); end
`endif
  endtask

  task test_lat1;
    rst_hold(); release_rst();
    checks++; if (f1.inst_sram_en !== 1'b1 || f1.inst_sram_addr !== 32'hbfc00000) begin errors++; $display("FAIL lat1_req0 got=%b/%h exp=1/bfc00000", f1.inst_sram_en, f1.inst_sram_addr); end
    tick(); #1;
    checks++; if (f1.fs_to_ds_valid !== 1'b0 || f1.inst_sram_en !== 1'b0) begin errors++; $display("FAIL lat1_wait got=%b/%b exp=0/0", f1.fs_to_ds_valid, f1.inst_sram_en); end
    tick(); #1;
    checks++; if (f1.fs_to_ds_valid !== 1'b1 || f1.fs_pc !== 32'hbfc00000 || f1.fs_inst !== 32'h403f0000) begin errors++; $display("FAIL lat1_v0 got=%b/%h/%h exp=1/bfc00000/403f0000", f1.fs_to_ds_valid, f1.fs_pc, f1.fs_inst); end
    checks++; if (f1.inst_sram_en !== 1'b1 || f1.inst_sram_addr !== 32'hbfc00004) begin errors++; $display("FAIL lat1_req1 got=%b/%h exp=1/bfc00004", f1.inst_sram_en, f1.inst_sram_addr); end
    tick(); tick(); #1;
    checks++; if (f1.fs_to_ds_valid !== 1'b1 || f1.fs_pc !== 32'hbfc00004 || f1.fs_inst !== 32'h403f0004) begin errors++; $display("FAIL lat1_v1 got=%b/%h/%h exp=1/bfc00004/403f0004", f1.fs_to_ds_valid, f1.fs_pc, f1.fs_inst); end
  endtask

  task test_lat3;
    logic [31:0] ep, ei;
    rst_hold(); release_rst();
    for (int k = 0; k < 3; k++) begin
      ep = 32'hbfc00000 + 32'(4 * k);
      ei = 32'h403f0000 + 32'(4 * k);
      for (int c = 1; c < 4; c++) begin
        tick(); #1;
        checks++; if (f3.fs_to_ds_valid !== 1'b0 || f3.inst_sram_en !== 1'b0) begin errors++; $display("FAIL lat3_gap k=%0d c=%0d got=%b/%b exp=0/0", k, c, f3.fs_to_ds_valid, f3.inst_sram_en); end
      end
      tick(); #1;
      checks++; if (f3.fs_to_ds_valid !== 1'b1 || f3.fs_pc !== ep || f3.fs_inst !== ei) begin errors++; $display("FAIL lat3_v k=%0d got=%b/%h/%h exp=1/%h/%h", k, f3.fs_to_ds_valid, f3.fs_pc, f3.fs_inst, ep, ei); end
    end
  endtask

  task test_stall;
    rst_hold(); f1.ds_allowin = 1'b0; release_rst();
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (f1.fs_to_ds_valid !== 1'b1 || f1.fs_pc !== 32'hbfc00000 || f1.fs_inst !== 32'h403f0000 || f1.inst_sram_en !== 1'b0) begin errors++; $display("FAIL stall_hold c=%0d got=%b/%h/%h en=%b exp=1/bfc00000/403f0000 en=0", c, f1.fs_to_ds_valid, f1.fs_pc, f1.fs_inst, f1.inst_sram_en); end
      tick();
    end
    f1.ds_allowin = 1'b1; #1;
    checks++; if (f1.inst_sram_en !== 1'b1 || f1.inst_sram_addr !== 32'hbfc00004) begin errors++; $display("FAIL stall_req got=%b/%h exp=1/bfc00004", f1.inst_sram_en, f1.inst_sram_addr); end
    tick(); tick(); #1;
    checks++; if (f1.fs_to_ds_valid !== 1'b1 || f1.fs_pc !== 32'hbfc00004 || f1.fs_inst !== 32'h403f0004) begin errors++; $display("FAIL stall_next got=%b/%h/%h exp=1/bfc00004/403f0004", f1.fs_to_ds_valid, f1.fs_pc, f1.fs_inst); end
  endtask

  task test_br_wait;
    rst_hold(); release_rst();
    tick(); f3.br_valid = 1'b1; f3.br_target = 32'hbfc00100;
    for (int c = 1; c < 4; c++) begin
      #1;
      checks++; if (f3.fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL brw_drop c=%0d got=%b exp=0", c, f3.fs_to_ds_valid); end
      tick(); f3.br_valid = 1'b0;
    end
    #1;
    checks++; if (f3.fs_to_ds_valid !== 1'b0 || f3.inst_sram_en !== 1'b1 || f3.inst_sram_addr !== 32'hbfc00100) begin errors++; $display("FAIL brw_req got=%b/%b/%h exp=0/1/bfc00100", f3.fs_to_ds_valid, f3.inst_sram_en, f3.inst_sram_addr); end
    tick(); tick(); tick(); tick(); #1;
    checks++; if (f3.fs_to_ds_valid !== 1'b1 || f3.fs_pc !== 32'hbfc00100 || f3.fs_inst !== 32'h403f0100) begin errors++; $display("FAIL brw_v got=%b/%h/%h exp=1/bfc00100/403f0100", f3.fs_to_ds_valid, f3.fs_pc, f3.fs_inst); end
  endtask

  task test_br_valid;
    rst_hold(); release_rst();
    tick(); tick(); f1.br_valid = 1'b1; f1.br_target = 32'hbfc00200; #1;
    checks++; if (f1.fs_to_ds_valid !== 1'b0 || f1.inst_sram_en !== 1'b0) begin errors++; $display("FAIL brv_kill got=%b/%b exp=0/0", f1.fs_to_ds_valid, f1.inst_sram_en); end
    tick(); f1.br_valid = 1'b0; #1;
    checks++; if (f1.fs_to_ds_valid !== 1'b0 || f1.inst_sram_en !== 1'b1 || f1.inst_sram_addr !== 32'hbfc00200) begin errors++; $display("FAIL brv_req got=%b/%b/%h exp=0/1/bfc00200", f1.fs_to_ds_valid, f1.inst_sram_en, f1.inst_sram_addr); end
    tick(); tick(); #1;
    checks++; if (f1.fs_to_ds_valid !== 1'b1 || f1.fs_pc !== 32'hbfc00200 || f1.fs_inst !== 32'h403f0200) begin errors++; $display("FAIL brv_v got=%b/%h/%h exp=1/bfc00200/403f0200", f1.fs_to_ds_valid, f1.fs_pc, f1.fs_inst); end
  endtask

  task test_wrap;
    rst_hold(); f1.br_valid = 1'b1; f1.br_target = 32'hfffffffc; release_rst();
    checks++; if (f1.inst_sram_en !== 1'b1 || f1.inst_sram_addr !== 32'hfffffffc) begin errors++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", f1.inst_sram_en, f1.inst_sram_addr); end
    tick(); f1.br_valid = 1'b0; tick(); #1;
    checks++; if (f1.fs_pc !== 32'hfffffffc || f1.fs_inst !== 32'h0000fffc || f1.inst_sram_addr !== 32'h0) begin errors++; $display("FAIL wrap_step got=%h/%h/%h exp=fffffffc/0000fffc/00000000", f1.fs_pc, f1.fs_inst, f1.inst_sram_addr); end
    tick(); tick(); #1;
    checks++; if (f1.fs_to_ds_valid !== 1'b1 || f1.fs_pc !== 32'h0 || f1.fs_inst !== 32'hffff0000) begin errors++; $display("FAIL wrap_v got=%b/%h/%h exp=1/00000000/ffff0000", f1.fs_to_ds_valid, f1.fs_pc, f1.fs_inst); end
  endtask

`ifdef FETCH_ADEL_EN
  task test_adel;
    rst_hold(); f1.br_valid = 1'b1; f1.br_target = 32'hbfc00102; release_rst();
    checks++; if (f1.inst_sram_en !== 1'b0) begin errors++; $display("FAIL adel_noreq got=%b exp=0", f1.inst_sram_en); end
    tick(); f1.br_valid = 1'b0; f1.ds_allowin = 1'b0; #1;
    checks++; if (f1.fs_to_ds_valid !== 1'b1 || f1.fs_adel !== 1'b1 || f1.fs_inst !== 32'h0 || f1.fs_pc !== 32'hbfc00102) begin errors++; $display("FAIL adel_v got=%b/%b/%h/%h exp=1/1/0/bfc00102", f1.fs_to_ds_valid, f1.fs_adel, f1.fs_inst, f1.fs_pc); end
  endtask
`endif

  initial begin
    idle(); rstn1 = 1'b0; rstn3 = 1'b0;
    test_reset();
    test_lat1();
    test_lat3();
    test_stall();
    test_br_wait();
    test_br_valid();
    test_wrap();
`ifdef FETCH_ADEL_EN
    test_adel();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Parametrised instruction-fetch stage for the pipelined MIPS core; drives the instruction SRAM and hands {pc, inst} to ID via a valid/allowin handshake.
- Generalises the fixed 2-cycle fetch to a configurable SRAM read latency.
- Adds branch redirect, with kill of in-flight or held fetches.
- Sits between the PC source and the ID stage inside mycpu_top.

Parameters:
- RESET_PC, 32'hbfc00000, PC loaded on reset.
- SRAM_LAT, 1, cycles from inst_sram_en to valid inst_sram_rdata; legal range 1..4.
- CNT_W, 3, latency counter width; must satisfy 2^CNT_W > SRAM_LAT.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous reset, active-low.
- inst_sram_en  out  1  read request strobe.
- inst_sram_wen  out  4  tied 4'h0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  tied 32'h0.
- inst_sram_rdata  in  32  read data, valid SRAM_LAT cycles after the request.
- ds_allowin  in  1  ID can accept this cycle.
- br_valid  in  1  redirect pulse from ID/EX.
- br_target  in  32  redirect PC.
- fs_to_ds_valid  out  1  {fs_pc, fs_inst} valid toward ID.
- fs_pc  out  32  PC of the held instruction.
- fs_inst  out  32  held instruction word.

Behaviour:
- One clock. Reset is synchronous and active-low.
- States: S_REQ, S_WAIT, S_VALID.
- Reset state: S_REQ, pc=RESET_PC, cnt=0, kill=0, inst_q=0, fs_to_ds_valid=0, inst_sram_en=0.
- S_REQ:
  - inst_sram_en=1, addr=pc.
  - If br_valid: addr=br_target, pc<=br_target.
  - Next state S_WAIT, cnt<=1.
- S_WAIT:
  - cnt increments each cycle.
  - When cnt==SRAM_LAT: inst_q<=inst_sram_rdata. If kill is clear, go to S_VALID; if kill is set, go to S_REQ and clear kill.
  - br_valid in S_WAIT: pc<=br_target, kill<=1. The in-flight word is discarded on return. A later br_valid overwrites pc.
- S_VALID:
  - fs_to_ds_valid = (state==S_VALID) && !br_valid.
  - Handshake occurs when fs_to_ds_valid && ds_allowin. In that same cycle: inst_sram_en=1, addr=pc+4, pc<=pc+4, cnt<=1, go to S_WAIT.
  - br_valid in S_VALID wins over the handshake. The held instruction is dropped, pc<=br_target, go to S_REQ.
  - Otherwise hold pc and inst_q stable until ID accepts.
- Throughput: one instruction per SRAM_LAT+1 cycles while ID never stalls.
- First valid after reset release: SRAM_LAT+1 cycles.
- fs_pc=pc, fs_inst=inst_q; both are stable while fs_to_ds_valid && !ds_allowin.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hfffffffc -> 32'h0).
- inst_sram_en is never asserted in S_WAIT, so at most one request is outstanding.
- Reset mid-operation: return to the reset state next cycle. Any SRAM return still in flight is ignored.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- Enabled:
  - Extra output port fs_adel (1 bit, reset 0).
  - If the PC about to be requested has bits [1:0] != 0: no SRAM request is issued. Go directly to S_VALID with inst_q=0 and fs_adel=1.
  - fs_adel clears when the next request is issued.
- Disabled: no port. Low PC bits pass to inst_sram_addr unchanged.

Decomposition:
- Shared package/header:
  - State encodings FS_REQ, FS_WAIT, FS_VALID.
  - Default RESET_PC.
  - Constant PC_STEP=4.
  - Tie-off constants for wen/wdata.
- No sub-module. The latency counter and FSM are small enough to live in one module.

Test Plan:
- Reset release, SRAM_LAT=1, ds_allowin=1: request at bfc00000; fs_to_ds_valid high 2 cycles later; next request is bfc00004.
- SRAM_LAT=3, ds_allowin=1: valid pulses every 4 cycles with PCs bfc00000, bfc00004, bfc00008.
- ID stall: ds_allowin=0 for 5 cycles in S_VALID. fs_pc/fs_inst hold stable, inst_sram_en stays 0, and the next PC is issued on the first allowin cycle.
- br_valid with br_target=bfc00100 during S_WAIT: the returning word is dropped (no valid), the next request goes to bfc00100, and the first valid has fs_pc=bfc00100.
- br_valid with ds_allowin=1 in S_VALID: fs_to_ds_valid=0 that cycle, the held instruction is never transferred, and the next request is br_target.
- FETCH_ADEL_EN, br_target=bfc00102: no SRAM request; valid with fs_adel=1 and fs_inst=0 on the following cycle.
